// File: rtl/timer_dev_if.sv
// Bus port of the timer: bridge-side address/write strobe/data in, read data and interrupt out.
interface timer_dev_if;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        IRQ;

  modport master (output Addr, WE, WD, input RD, IRQ);
  modport slave  (input Addr, WE, WD, output RD, IRQ);
endinterface

// File: rtl/timer_dev.sv
// Memory-mapped 32-bit countdown timer with CTRL/PRESET/COUNT registers,
// one-shot or auto-reload operation and a maskable interrupt.
module timer_dev (
  input  logic       clk,
  input  logic       reset,
  timer_dev_if.slave bus
);
  localparam int unsigned DW = 32;
  localparam logic [1:0] SEL_CTRL    = 2'd0;
  localparam logic [1:0] SEL_PRESET  = 2'd1;
  localparam logic [1:0] SEL_COUNT   = 2'd2;
  localparam logic [1:0] MODE_RELOAD = 2'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t        r_state;
  logic [3:0]    r_ctrl;
  logic [DW-1:0] r_preset;
  logic [DW-1:0] r_count;
  logic          r_irq_pend;

  logic [1:0]    w_sel;
  logic          w_en;
  logic [1:0]    w_mode;
  logic          w_unused_addr;

  assign w_sel         = bus.Addr[3:2];
  assign w_en          = r_ctrl[0];
  assign w_mode        = r_ctrl[2:1];
  assign w_unused_addr = ^{bus.Addr[31:4], bus.Addr[1:0]};

  // FSM acts on the pre-edge ctrl; a same-edge CPU write is applied last so it wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ctrl     <= '0;
      r_preset   <= '0;
      r_count    <= '0;
      r_irq_pend <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_en) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_count    <= r_preset;
          r_irq_pend <= 1'b0;
          r_state    <= S_CNT;
        end
        S_CNT: begin
          if (!w_en) begin
            r_state <= S_IDLE;
          end else if (r_count > DW'(1)) begin
            r_count <= r_count - DW'(1);
          end else begin
            r_count    <= '0;
            r_irq_pend <= 1'b1;
            r_state    <= S_INT;
          end
        end
        S_INT: begin
          if (w_mode == MODE_RELOAD) begin
            r_irq_pend <= 1'b0;
            r_state    <= S_LOAD;
          end else begin
            r_ctrl[0] <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (bus.WE) begin
        case (w_sel)
          SEL_CTRL: begin
            r_ctrl     <= bus.WD[3:0];
            r_irq_pend <= 1'b0;
          end
          SEL_PRESET: r_preset <= bus.WD;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus.RD = '0;
    case (w_sel)
      SEL_CTRL:   bus.RD = {28'b0, r_ctrl};
      SEL_PRESET: bus.RD = r_preset;
      SEL_COUNT:  bus.RD = r_count;
      default:    bus.RD = '0;
    endcase
  end

  assign bus.IRQ = r_irq_pend & r_ctrl[3];
endmodule
